// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: iterative radix-2 shift-add multiply and restoring divide.
// Optional MULDIV_FAST_MUL_EN selects a single-cycle combinational multiplier for MUL* ops.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic            ex_stall,
    input  logic            ex_flush,
    output logic            muldiv_stall_req,
    output logic [XLEN-1:0] muldiv_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_count;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_result;
    logic [2:0]        r_op;
    logic              r_negQ;
    logic              r_negR;

    logic              w_isMul;
    logic              w_signedA;
    logic              w_signedB;
    logic              w_sA;
    logic              w_sB;
    logic [XLEN-1:0]   w_absA;
    logic [XLEN-1:0]   w_absB;
    logic              w_divZero;
    logic              w_overflow;
    logic [XLEN-1:0]   w_specialResult;
    logic              w_start;
    logic              w_fastSel;
    logic [XLEN-1:0]   w_fastResult;

    logic [XLEN:0]     w_remShift;
    logic [XLEN:0]     w_diff;
    logic [XLEN:0]     w_sum;
    logic [XLEN-1:0]   w_remNext;
    logic [XLEN-1:0]   w_quoNext;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prodSigned;
    logic [XLEN-1:0]   w_quoSigned;
    logic [XLEN-1:0]   w_remSigned;
    logic [XLEN-1:0]   w_finalResult;

    assign w_isMul    = ~req_op[2];
    assign w_signedA  = (req_op == 3'd0) | (req_op == 3'd1) | (req_op == 3'd2) |
                        (req_op == 3'd4) | (req_op == 3'd6);
    assign w_signedB  = (req_op == 3'd0) | (req_op == 3'd1) |
                        (req_op == 3'd4) | (req_op == 3'd6);
    assign w_sA       = w_signedA & req_rs1[XLEN-1];
    assign w_sB       = w_signedB & req_rs2[XLEN-1];
    assign w_absA     = w_sA ? (~req_rs1 + 1'b1) : req_rs1;
    assign w_absB     = w_sB ? (~req_rs2 + 1'b1) : req_rs2;

    assign w_divZero  = req_op[2] & (req_rs2 == '0);
    assign w_overflow = req_op[2] & ~req_op[0] &
                        (req_rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (&req_rs2);

    // Divide-by-zero and signed overflow resolve without iterating.
    always_comb begin
        w_specialResult = '0;
        if (w_divZero)
            w_specialResult = req_op[1] ? req_rs1 : '1;
        else
            w_specialResult = req_op[1] ? '0 : req_rs1;
    end

    // One step: divide shifts the dividend into the partial remainder, multiply adds then shifts right.
    assign w_remShift = {r_rem, r_quo[XLEN-1]};
    assign w_diff     = w_remShift - {1'b0, r_b};
    assign w_sum      = {1'b0, r_rem} + (r_quo[0] ? {1'b0, r_a} : '0);
    assign w_remNext  = r_op[2] ? (w_diff[XLEN] ? w_remShift[XLEN-1:0] : w_diff[XLEN-1:0])
                                : w_sum[XLEN:1];
    assign w_quoNext  = r_op[2] ? {r_quo[XLEN-2:0], ~w_diff[XLEN]}
                                : {w_sum[0], r_quo[XLEN-1:1]};

    assign w_prod       = {w_remNext, w_quoNext};
    assign w_prodSigned = r_negQ ? (~w_prod + 1'b1) : w_prod;
    assign w_quoSigned  = r_negQ ? (~w_quoNext + 1'b1) : w_quoNext;
    assign w_remSigned  = r_negR ? (~w_remNext + 1'b1) : w_remNext;

    always_comb begin
        w_finalResult = '0;
        case (r_op)
            3'd0:                   w_finalResult = w_prodSigned[XLEN-1:0];
            3'd1, 3'd2, 3'd3:       w_finalResult = w_prodSigned[2*XLEN-1:XLEN];
            3'd4, 3'd5:             w_finalResult = w_quoSigned;
            default:                w_finalResult = w_remSigned;
        endcase
    end

`ifdef MULDIV_FAST_MUL_EN
    // Operands sign-extended per op, so a plain signed multiply covers all four MUL variants.
    logic signed [2*XLEN-1:0] w_fastA;
    logic signed [2*XLEN-1:0] w_fastB;
    logic signed [2*XLEN-1:0] w_fastProd;

    assign w_fastA      = {{XLEN{w_sA}}, req_rs1};
    assign w_fastB      = {{XLEN{w_sB}}, req_rs2};
    assign w_fastProd   = w_fastA * w_fastB;
    assign w_fastResult = (req_op[1:0] == 2'd0) ? w_fastProd[XLEN-1:0]
                                                : w_fastProd[2*XLEN-1:XLEN];
    assign w_fastSel    = req_valid & (r_state == IDLE) & w_isMul;
`else
    assign w_fastResult = '0;
    assign w_fastSel    = 1'b0;
`endif

    assign w_start          = req_valid & ~ex_flush & (r_state == IDLE) & ~w_fastSel;
    assign muldiv_stall_req = req_valid & ~rst & ~ex_flush & (r_state != DONE) & ~w_fastSel;
    assign muldiv_result    = w_fastSel ? w_fastResult : r_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_result <= '0;
            r_op     <= '0;
            r_negQ   <= 1'b0;
            r_negR   <= 1'b0;
        end else if (ex_flush) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_a     <= w_absA;
                        r_b     <= w_absB;
                        r_rem   <= '0;
                        r_quo   <= w_isMul ? w_absB : w_absA;
                        r_op    <= req_op;
                        r_negQ  <= w_sA ^ w_sB;
                        r_negR  <= w_sA;
                        r_count <= '0;
                        if (w_divZero | w_overflow) begin
                            r_result <= w_specialResult;
                            r_state  <= DONE;
                        end else begin
                            r_state  <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (!req_valid) begin
                        r_state <= IDLE;
                        r_count <= '0;
                    end else begin
                        r_rem <= w_remNext;
                        r_quo <= w_quoNext;
                        if (r_count == CNT_W'(XLEN-1)) begin
                            r_result <= w_finalResult;
                            r_state  <= DONE;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!ex_stall) begin
                        r_state <= IDLE;
                        r_count <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, results, special cases, flush and hold.
// Expected MUL* latency follows MULDIV_FAST_MUL_EN.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic        ex_stall;
    logic        ex_flush;
    logic        muldiv_stall_req;
    logic [31:0] muldiv_result;

    int checks   = 0;
    int failures = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_STALLS = 0;
`else
    localparam int MUL_STALLS = 33;
`endif

    muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_op           (req_op),
        .req_rs1          (req_rs1),
        .req_rs2          (req_rs2),
        .ex_stall         (ex_stall),
        .ex_flush         (ex_flush),
        .muldiv_stall_req (muldiv_stall_req),
        .muldiv_result    (muldiv_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] stateNow();
        return {30'd0, dut.r_state};
    endfunction

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_rs1   = a;
        req_rs2   = b;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Counts stall cycles until the result appears, then consumes the instruction.
    task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int expStalls, input logic [31:0] expRes);
        int n;
        applyStimulus(op, a, b);
        #1;
        n = 0;
        while (muldiv_stall_req && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        checkOutput({tag, "_stalls"}, n, expStalls);
        checkOutput({tag, "_result"}, muldiv_result, expRes);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        req_valid = 1'b1;
        req_op    = 3'd4;
        req_rs1   = 32'd100;
        req_rs2   = 32'd7;
        ex_stall  = 1'b0;
        ex_flush  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_stall", {31'd0, muldiv_stall_req}, 32'd0);
        checkOutput("reset_result", muldiv_result, 32'd0);
        checkOutput("reset_state", stateNow(), 32'd0);
        rst       = 1'b0;
        req_valid = 1'b0;
        @(posedge clk);
        #1;

        runOp("div_100_7",    3'd4, 32'd100,        32'd7,          33, 32'd14);
        runOp("rem_m100_7",   3'd6, 32'hFFFF_FF9C,  32'd7,          33, 32'hFFFF_FFFE);
        runOp("div_m7_2",     3'd4, 32'hFFFF_FFF9,  32'd2,          33, 32'hFFFF_FFFD);
        runOp("divu_by0",     3'd5, 32'h0000_1234,  32'd0,          1,  32'hFFFF_FFFF);
        runOp("remu_by0",     3'd7, 32'h0000_1234,  32'd0,          1,  32'h0000_1234);
        runOp("div_m5_by0",   3'd4, 32'hFFFF_FFFB,  32'd0,          1,  32'hFFFF_FFFF);
        runOp("rem_m5_by0",   3'd6, 32'hFFFF_FFFB,  32'd0,          1,  32'hFFFF_FFFB);
        runOp("div_ovf",      3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  1,  32'h8000_0000);
        runOp("rem_ovf",      3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  1,  32'h0000_0000);
        runOp("mulh_min",     3'd1, 32'h8000_0000,  32'h8000_0000,  MUL_STALLS, 32'h4000_0000);
        runOp("mulhu_max",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  MUL_STALLS, 32'hFFFF_FFFE);
        runOp("mul_7_m3",     3'd0, 32'd7,          32'hFFFF_FFFD,  MUL_STALLS, 32'hFFFF_FFEB);
        runOp("mulhsu_m1_2",  3'd2, 32'hFFFF_FFFF,  32'd2,          MUL_STALLS, 32'hFFFF_FFFF);

        // Flush in the tenth BUSY cycle, then a fresh divide must run its full latency.
        applyStimulus(3'd4, 32'd100, 32'd7);
        #1;
        repeat (10) @(posedge clk);
        #1;
        ex_flush = 1'b1;
        #1;
        checkOutput("flush_stall", {31'd0, muldiv_stall_req}, 32'd0);
        @(posedge clk);
        #1;
        ex_flush = 1'b0;
        checkOutput("flush_state", stateNow(), 32'd0);
        runOp("flush_div_9_3", 3'd4, 32'd9, 32'd3, 33, 32'd3);

        // Hold a finished result under ex_stall with the instruction still present.
        applyStimulus(3'd5, 32'h0000_1234, 32'd0);
        #1;
        n = 0;
        while (muldiv_stall_req && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        checkOutput("hold_stalls", n, 32'd1);
        ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("hold_result_%0d", i), muldiv_result, 32'hFFFF_FFFF);
            checkOutput($sformatf("hold_stall_%0d", i), {31'd0, muldiv_stall_req}, 32'd0);
            checkOutput($sformatf("hold_state_%0d", i), stateNow(), 32'd2);
            @(posedge clk);
            #1;
        end
        ex_stall  = 1'b0;
        checkOutput("hold_release_result", muldiv_result, 32'hFFFF_FFFF);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("hold_release_state", stateNow(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
